fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
// - Sequences instruction fetch for the MIPS32 core: owns the PC, issues
//   word fetches to instruction memory over a req/ack handshake, and buffers
//   returned words (2 entries) toward decode.
// - Resolves control-flow redirects from execute: branch, j/jal and jr.
//   It forms the jump target as {pc_4[31:28], target26, 2'b00}.
// - Sits between imem and the decode stage; replaces free-running PC+4 logic.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC fetched first after reset; bits[1:0] must be 0
// PORTS
// - clk             in   1   single clock, rising edge
// - rst_n           in   1   asynchronous, active-low reset
// - imem_req        out  1   fetch request; held with stable imem_addr until ack
// - imem_addr       out  32  word-aligned fetch address
// - imem_ack        in   1   one-cycle pulse; imem_rdata valid this cycle
// - imem_rdata      in   32  fetched instruction
// - if_valid        out  1   if_inst/if_pc_4 hold a valid instruction
// - if_inst         out  32  instruction to decode
// - if_pc_4         out  32  fetch address + 4 of if_inst
// - if_ready        in   1   decode accepts; transfer when if_valid&&if_ready
// - redir_valid     in   1   one-cycle redirect request from execute
// - redir_type      in   2   00 branch, 01 jump, 10 jr, 11 reserved (ignored)
// - redir_pc_4      in   32  pc_4 of the redirecting instruction
// - redir_imm       in   32  sign-extended word offset (branch)
// - redir_target26  in   26  instr[25:0] (jump)
// - redir_reg       in   32  rs value (jr)
// - fault           out  1   sticky: misaligned jr target; fetch halted
// BEHAVIOUR
// - Reset (rst_n=0, async) forces the following values:
//   - Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=0,
//     if_pc_4=0, fault=0.
//   - Internal: skid empty, state=S_REQ, pc=RESET_PC.
// - First rising edge after rst_n rises: imem_req=1, imem_addr=RESET_PC.
// - Handshake: once imem_req=1, imem_req and imem_addr stay stable until the
//   imem_ack cycle. Ack with req=0 is ignored.
// - Redirect targets (32-bit wrap, no overflow detect):
//   - branch: redir_pc_4 + (redir_imm<<2)
//   - jump: {redir_pc_4[31:28], redir_target26, 2'b00}
//   - jr: redir_reg; if redir_reg[1:0]!=0, fault<=1 and state->S_HALT
// - Buffer: output reg (if_*) plus 1-entry skid; skid drains to output first.
// - S_REQ, imem_req=1. On ack:
//   - word enters output reg if free or draining, else skid; pc<=pc+4.
//   - If skid is now full, ->S_HOLD; otherwise stay in S_REQ.
// - S_HOLD, imem_req=0. When skid moves to the output reg, ->S_REQ next cycle.
// - Redirect, any state except S_HALT:
//   - Output reg and skid are flushed next cycle (if_valid=0); pc<=target.
//   - Req outstanding without ack this cycle: ->S_SQUASH.
//   - Otherwise: ->S_REQ, and imem_addr=target on the next cycle.
// - S_SQUASH, imem_req=1 at the old address. On ack the data is discarded,
//   then ->S_REQ at the redirect target.
// - A second redirect while in S_SQUASH overwrites the target.
// - Redirect and ack in the same cycle: returned word discarded, target wins.
// - Redirect and decode transfer in the same cycle: the transfer completes,
//   the buffers are then flushed.
// - S_HALT: imem_req=0, if_valid=0 (flushed). Exited only by reset.
// - redir_type=11: no effect.
// - Throughput: 1 instr/cycle when imem acks in the request cycle and decode
//   is always ready. Latency: ack -> if_valid 1 cycle.
// STRUCTURE
// - Shared package (mips_pkg):
//   - redir_type encodings REDIR_BR/REDIR_J/REDIR_JR
//   - fetch FSM state enum {S_REQ,S_HOLD,S_SQUASH,S_HALT}
// - One sub-module: redir_target (combinational target mux plus misalign
//   flag); jump path formed inside it. The rest is a single always block.
// TESTING
// - Reset and streaming, ack in the same cycle as req, if_ready=1:
//   - imem_addr = 0, 4, 8, ... on consecutive cycles.
//   - if_pc_4 = 4, 8, 12 one cycle after each ack.
// - Backpressure (if_ready=0 after 1st word):
//   - 2nd word goes to skid, imem_req drops to 0 (S_HOLD), no word lost.
//   - After if_ready=1: words appear in order, then req resumes at addr+8.
// - Jump: redir_pc_4=32'h4000_0010, target26=26'h000_0100:
//   - next fetch at 32'h4000_0400; buffers flushed.
// - Branch during an outstanding request (ack delayed 3 cycles), imm=-2,
//   redir_pc_4=32'h20:
//   - req held at the old address until ack; acked data dropped.
//   - next fetch at 32'h18.
// - jr with redir_reg=32'h0000_1002:
//   - fault=1 and imem_req=0, and they stay so until rst_n pulse.
// - Redirect and ack in the same cycle: the acked word never reaches if_valid;
//   the next imem_addr is the target.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 front-end types: redirect encodings and fetch FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        REDIR_BR  = 2'b00,
        REDIR_J   = 2'b01,
        REDIR_JR  = 2'b10,
        REDIR_RSV = 2'b11
    } redir_type_e;

    typedef enum logic [1:0] {
        S_REQ    = 2'b00,
        S_HOLD   = 2'b01,
        S_SQUASH = 2'b10,
        S_HALT   = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_redir_target.sv
// Combinational redirect target mux; flags jr targets that are not word aligned.
module redir_target
    import mips_pkg::*;
(
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_pc_4,
    input  logic [31:0] redir_imm,
    input  logic [25:0] redir_target26,
    input  logic [31:0] redir_reg,
    output logic [31:0] target,
    output logic        misalign
);

    always_comb begin
        target   = redir_pc_4;
        misalign = 1'b0;
        case (redir_type_e'(redir_type))
            REDIR_BR: target = redir_pc_4 + {redir_imm[29:0], 2'b00};
            REDIR_J:  target = {redir_pc_4[31:28], redir_target26, 2'b00};
            REDIR_JR: begin
                target   = redir_reg;
                misalign = (redir_reg[1:0] != 2'b00);
            end
            default:  target = redir_pc_4;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the imem req/ack handshake,
// buffers returned words (output reg + skid) toward decode and applies redirects.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc_4,
    input  logic        if_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_pc_4,
    input  logic [31:0] redir_imm,
    input  logic [25:0] redir_target26,
    input  logic [31:0] redir_reg,
    output logic        fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  squash_addr_q, squash_addr_d;
    logic         started_q, started_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_inst_q, out_inst_d;
    logic [31:0]  out_pc4_q, out_pc4_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  skid_inst_q, skid_inst_d;
    logic [31:0]  skid_pc4_q, skid_pc4_d;
    logic         fault_q, fault_d;

    logic [31:0]  redir_tgt;
    logic         redir_misalign;
    logic         ack_ok;
    logic         drain;
    logic         redir_take;

    redir_target u_redir_target (
        .redir_type     (redir_type),
        .redir_pc_4     (redir_pc_4),
        .redir_imm      (redir_imm),
        .redir_target26 (redir_target26),
        .redir_reg      (redir_reg),
        .target         (redir_tgt),
        .misalign       (redir_misalign)
    );

    // started_q keeps imem_req low during the first cycle out of reset.
    assign imem_req   = started_q && ((state_q == S_REQ) || (state_q == S_SQUASH));
    assign imem_addr  = (state_q == S_SQUASH) ? squash_addr_q : pc_q;
    assign ack_ok     = imem_req && imem_ack;
    assign drain      = out_valid_q && if_ready;
    assign redir_take = redir_valid && (redir_type != REDIR_RSV) && (state_q != S_HALT);

    assign if_valid = out_valid_q;
    assign if_inst  = out_inst_q;
    assign if_pc_4  = out_pc4_q;
    assign fault    = fault_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_addr_d = squash_addr_q;
        started_d     = 1'b1;
        out_valid_d   = out_valid_q;
        out_inst_d    = out_inst_q;
        out_pc4_d     = out_pc4_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_pc4_d    = skid_pc4_q;
        fault_d       = fault_q;

        if (drain) begin
            if (skid_valid_q) begin
                out_inst_d   = skid_inst_q;
                out_pc4_d    = skid_pc4_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        case (state_q)
            S_REQ: begin
                if (ack_ok) begin
                    pc_d = pc_q + 32'd4;
                    if ((!out_valid_q || drain) && !skid_valid_q) begin
                        out_valid_d = 1'b1;
                        out_inst_d  = imem_rdata;
                        out_pc4_d   = pc_q + 32'd4;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_inst_d  = imem_rdata;
                        skid_pc4_d   = pc_q + 32'd4;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!skid_valid_d) state_d = S_REQ;
            end
            S_SQUASH: begin
                if (ack_ok) state_d = S_REQ;
            end
            S_HALT: begin
                out_valid_d  = 1'b0;
                skid_valid_d = 1'b0;
            end
            default: state_d = S_REQ;
        endcase

        // A redirect overrides any buffering decision made above this cycle.
        if (redir_take) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if (redir_misalign) begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end else begin
                pc_d = redir_tgt;
                if (imem_req && !imem_ack) begin
                    state_d       = S_SQUASH;
                    squash_addr_d = imem_addr;
                end else begin
                    state_d = S_REQ;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            squash_addr_q <= RESET_PC;
            started_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_inst_q    <= 32'h0;
            out_pc4_q     <= 32'h0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= 32'h0;
            skid_pc4_q    <= 32'h0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_addr_q <= squash_addr_d;
            started_q     <= started_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_pc4_q     <= out_pc4_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc4_q    <= skid_pc4_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, backpressure, redirects and fault halt.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc_4;
    logic        if_ready = 1'b1;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_type = 2'b00;
    logic [31:0] redir_pc_4 = 32'h0;
    logic [31:0] redir_imm = 32'h0;
    logic [25:0] redir_target26 = 26'h0;
    logic [31:0] redir_reg = 32'h0;
    logic        fault;

    int total = 0;
    int bad = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc_4        (if_pc_4),
        .if_ready       (if_ready),
        .redir_valid    (redir_valid),
        .redir_type     (redir_type),
        .redir_pc_4     (redir_pc_4),
        .redir_imm      (redir_imm),
        .redir_target26 (redir_target26),
        .redir_reg      (redir_reg),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b1;
        redir_valid    = 1'b0;
        redir_type     = 2'b00;
        redir_pc_4     = 32'h0;
        redir_imm      = 32'h0;
        redir_target26 = 26'h0;
        redir_reg      = 32'h0;
    endtask

    // Leaves the DUT one cycle past reset release: imem_req=1 at RESET_PC.
    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req got=%0b want=0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_addr got=%h want=0", imem_addr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%0b want=0", if_valid); end
        total++; if (if_inst !== 32'h0) begin bad++; $display("[TB] FAIL rst_inst got=%h want=0", if_inst); end
        total++; if (if_pc_4 !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc4 got=%h want=0", if_pc_4); end
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL rst_fault got=%0b want=0", fault); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rel_req got=%0b want=0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL first_req got=%0b want=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL first_addr got=%h want=0", imem_addr); end
    endtask

    task automatic test_streaming;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL stream_req%0d got=%0b want=1", i, imem_req); end
            total++; if (imem_addr !== 32'(4 * i)) begin bad++; $display("[TB] FAIL stream_addr%0d got=%h want=%h", i, imem_addr, 32'(4 * i)); end
            imem_ack   = 1'b1;
            imem_rdata = 32'hA000_0000 + 32'(i);
            tick();
            total++; if (if_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid%0d got=%0b want=1", i, if_valid); end
            total++; if (if_pc_4 !== 32'(4 * i + 4)) begin bad++; $display("[TB] FAIL stream_pc4_%0d got=%h want=%h", i, if_pc_4, 32'(4 * i + 4)); end
            total++; if (if_inst !== 32'hA000_0000 + 32'(i)) begin bad++; $display("[TB] FAIL stream_inst%0d got=%h want=%h", i, if_inst, 32'hA000_0000 + 32'(i)); end
        end
        imem_ack = 1'b0;
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_drain got=%0b want=0", if_valid); end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("[TB] FAIL stream_next_addr got=%h want=10", imem_addr); end
    endtask

    task automatic test_backpressure;
        do_reset();
        if_ready   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hB000_0000;
        tick();
        total++; if (if_pc_4 !== 32'h4) begin bad++; $display("[TB] FAIL bp_w0_pc4 got=%h want=4", if_pc_4); end
        total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL bp_w1_req got=%0b/%h want=1/4", imem_req, imem_addr); end
        imem_rdata = 32'hB000_0001;
        tick();
        imem_ack = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_req got=%0b want=0", imem_req); end
        total++; if (if_inst !== 32'hB000_0000 || if_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_out got=%0b/%h want=1/b0000000", if_valid, if_inst); end
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold2_req got=%0b want=0", imem_req); end
        if_ready = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_pc_4 !== 32'h8) begin bad++; $display("[TB] FAIL bp_skid_out got=%0b/%h want=1/8", if_valid, if_pc_4); end
        total++; if (if_inst !== 32'hB000_0001) begin bad++; $display("[TB] FAIL bp_skid_inst got=%h want=b0000001", if_inst); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL bp_resume got=%0b/%h want=1/8", imem_req, imem_addr); end
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%0b want=0", if_valid); end
    endtask

    task automatic test_jump;
        do_reset();
        if_ready   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hC000_0000;
        tick();
        imem_rdata = 32'hC000_0001;
        tick();
        imem_ack       = 1'b0;
        redir_valid    = 1'b1;
        redir_type     = 2'b01;
        redir_pc_4     = 32'h4000_0010;
        redir_target26 = 26'h000_0100;
        tick();
        redir_valid = 1'b0;
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL j_flush got=%0b want=0", if_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0400) begin bad++; $display("[TB] FAIL j_target got=%0b/%h want=1/40000400", imem_req, imem_addr); end
        if_ready = 1'b1;
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL j_skid_gone got=%0b want=0", if_valid); end
    endtask

    task automatic test_branch_squash;
        do_reset();
        redir_valid = 1'b1;
        redir_type  = 2'b00;
        redir_pc_4  = 32'h20;
        redir_imm   = 32'hFFFF_FFFE;
        tick();
        redir_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL br_sq1 got=%0b/%h want=1/0", imem_req, imem_addr); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL br_sq2 got=%0b/%h want=1/0", imem_req, imem_addr); end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL br_drop got=%0b want=0", if_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin bad++; $display("[TB] FAIL br_target got=%0b/%h want=1/18", imem_req, imem_addr); end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc_4 !== 32'h1C) begin bad++; $display("[TB] FAIL br_first got=%0b/%h want=1/1c", if_valid, if_pc_4); end
        total++; if (if_inst !== 32'h1234_5678) begin bad++; $display("[TB] FAIL br_inst got=%h want=12345678", if_inst); end
    endtask

    task automatic test_jr_fault;
        do_reset();
        redir_valid = 1'b1;
        redir_type  = 2'b10;
        redir_reg   = 32'h0000_1002;
        tick();
        total++; if (fault !== 1'b1) begin bad++; $display("[TB] FAIL jr_fault got=%0b want=1", fault); end
        total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("[TB] FAIL jr_halt got=%0b/%0b want=0/0", imem_req, if_valid); end
        redir_type     = 2'b01;
        redir_target26 = 26'h40;
        imem_ack       = 1'b1;
        repeat (3) tick();
        redir_valid = 1'b0;
        imem_ack    = 1'b0;
        total++; if (fault !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL jr_sticky got=%0b/%0b want=1/0", fault, imem_req); end
        do_reset();
        total++; if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL jr_recover got=%0b/%0b/%h want=0/1/0", fault, imem_req, imem_addr); end
    endtask

    task automatic test_redir_with_ack;
        do_reset();
        imem_ack    = 1'b1;
        imem_rdata  = 32'h1111_1111;
        redir_valid = 1'b1;
        redir_type  = 2'b00;
        redir_pc_4  = 32'h100;
        redir_imm   = 32'h4;
        tick();
        imem_ack    = 1'b0;
        redir_valid = 1'b0;
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL ra_drop got=%0b want=0", if_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin bad++; $display("[TB] FAIL ra_target got=%0b/%h want=1/110", imem_req, imem_addr); end
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("[TB] FAIL ra_still got=%0b want=0", if_valid); end
    endtask

    task automatic test_reserved;
        do_reset();
        redir_valid = 1'b1;
        redir_type  = 2'b11;
        redir_reg   = 32'h0000_1002;
        redir_pc_4  = 32'h8000_0000;
        tick();
        redir_valid = 1'b0;
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL rsv_fault got=%0b want=0", fault); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rsv_addr got=%0b/%h want=1/0", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_jump();
        test_branch_squash();
        test_jr_fault();
        test_redir_with_ack();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
